// File: rtl/alu_mem_stage.sv
// alu_mem_stage: execute/memory stage of a single-cycle LEGv8 datapath.
// The ALU control decode, the 64-bit ALU and the data-memory read path are combinational.
// The data memory is word-organised and cleared asynchronously by Reset.
module alu_mem_stage #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  ALUop,
  input  logic [10:0] Opcode,
  input  logic        ALUSrc,
  input  logic [63:0] BusA,
  input  logic [63:0] BusB,
  input  logic [63:0] Imm,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  output logic [3:0]  ALUCtrl,
  output logic [63:0] ALUResult,
  output logic        Zero,
  output logic [63:0] ReadData
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  // main-control ALUop encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // R-type opcodes, instruction[31:21]
  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  // ALU operation codes
  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_ORR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;
  localparam logic [3:0] CTRL_INV   = 4'b1111;

  logic [3:0]        alu_ctrl_c;
  logic [DATA_W-1:0] op_b_c;
  logic [DATA_W-1:0] alu_res_c;
  logic [ADDR_W-1:0] mem_idx_c;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // ALU control decode from ALUop and the R-type opcode field
  always_comb begin
    alu_ctrl_c = CTRL_INV;
    unique case (ALUop)
      ALUOP_ADD:   alu_ctrl_c = CTRL_ADD;
      ALUOP_PASSB: alu_ctrl_c = CTRL_PASSB;
      ALUOP_RTYPE: begin
        unique case (Opcode)
          OPC_ADD: alu_ctrl_c = CTRL_ADD;
          OPC_SUB: alu_ctrl_c = CTRL_SUB;
          OPC_AND: alu_ctrl_c = CTRL_AND;
          OPC_ORR: alu_ctrl_c = CTRL_ORR;
          default: alu_ctrl_c = CTRL_INV;
        endcase
      end
      default:     alu_ctrl_c = CTRL_INV;
    endcase
  end

  // operand B select: immediate for loads/stores/ADDI, register otherwise
  assign op_b_c = ALUSrc ? Imm : BusB;

  // 64-bit ALU; carry and borrow wrap, unsupported codes give zero
  always_comb begin
    alu_res_c = '0;
    unique case (alu_ctrl_c)
      CTRL_AND:   alu_res_c = BusA & op_b_c;
      CTRL_ORR:   alu_res_c = BusA | op_b_c;
      CTRL_ADD:   alu_res_c = BusA + op_b_c;
      CTRL_SUB:   alu_res_c = BusA - op_b_c;
      CTRL_PASSB: alu_res_c = op_b_c;
      default:    alu_res_c = '0;
    endcase
  end

  // word index: byte offset dropped, high address bits wrap modulo depth
  assign mem_idx_c = alu_res_c[ADDR_W+2:3];

  // data memory: async clear on Reset low, word write on rising Clk
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemoryWrite) begin
      mem_q[mem_idx_c] <= BusB;
    end
  end

  assign ALUCtrl   = alu_ctrl_c;
  assign ALUResult = alu_res_c;
  assign Zero      = (alu_res_c == '0);
  // read returns the stored word with no write bypass
  assign ReadData  = MemoryRead ? mem_q[mem_idx_c] : '0;

endmodule

// File: tb/tb_alu_mem_stage.sv
// tb_alu_mem_stage: directed bench for alu_mem_stage with a behavioural reference model.
module tb_alu_mem_stage;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  ALUop;
  logic [10:0] Opcode;
  logic        ALUSrc;
  logic [63:0] BusA, BusB, Imm;
  logic        MemoryRead, MemoryWrite;
  logic [3:0]  ALUCtrl;
  logic [63:0] ALUResult;
  logic        Zero;
  logic [63:0] ReadData;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;
  logic [63:0] m_mem [32];

  alu_mem_stage #(.ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .ALUop(ALUop), .Opcode(Opcode), .ALUSrc(ALUSrc),
    .BusA(BusA), .BusB(BusB), .Imm(Imm), .MemoryRead(MemoryRead),
    .MemoryWrite(MemoryWrite), .ALUCtrl(ALUCtrl), .ALUResult(ALUResult),
    .Zero(Zero), .ReadData(ReadData)
  );

  always #5 Clk = ~Clk;

  // reference: ALU control table
  function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd7;
    if (op == 2'd2) begin
      if (opc == OP_ADD) return 4'd2;
      if (opc == OP_SUB) return 4'd6;
      if (opc == OP_AND) return 4'd0;
      if (opc == OP_ORR) return 4'd1;
    end
    return 4'hF;
  endfunction

  // reference: ALU result from operation code and operands
  function automatic logic [63:0] m_alu(input logic [3:0] c, input logic [63:0] a,
                                        input logic [63:0] b);
    if (c == 4'd0) return a & b;
    if (c == 4'd1) return a | b;
    if (c == 4'd2) return a + b;
    if (c == 4'd6) return a - b;
    if (c == 4'd7) return b;
    return 64'd0;
  endfunction

  function automatic logic [63:0] m_res();
    return m_alu(m_ctrl(ALUop, Opcode), BusA, ALUSrc ? Imm : BusB);
  endfunction

  function automatic int m_index();
    logic [63:0] r;
    r = m_res();
    return int'((r / 64'd8) % 64'd32);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference memory: writes on rising edge only while Reset is high
  always @(posedge Clk) begin
    if (Reset === 1'b1 && MemoryWrite === 1'b1) m_mem[m_index()] = BusB;
  end

  // reference memory: clear when Reset falls
  always @(negedge Reset) begin
    for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
  end

  // every-cycle comparison against the reference, away from the active edge
  always @(negedge Clk) begin
    if (check_en) begin
      check("cyc_ctrl", 64'(ALUCtrl), 64'(m_ctrl(ALUop, Opcode)));
      check("cyc_res",  ALUResult, m_res());
      check("cyc_zero", 64'(Zero), 64'(m_res() == 64'd0));
      check("cyc_rdata", ReadData, MemoryRead ? m_mem[m_index()] : 64'd0);
    end
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_alu(input logic [1:0] op, input logic [10:0] opc, input logic src,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
    ALUop = op; Opcode = opc; ALUSrc = src; BusA = a; BusB = b; Imm = im;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
    Reset = 1'b0;
    set_alu(2'b00, 11'd0, 1'b1, 64'd0, 64'd0, 64'd24);
    MemoryRead = 1'b1; MemoryWrite = 1'b0;
    next_cycle();
    next_cycle();
    #1 Reset = 1'b1;
    check_en = 1'b1;
    #1 check("reset_rdata", ReadData, 64'd0);

    // ADD
    next_cycle();
    MemoryRead = 1'b0;
    set_alu(2'b10, OP_ADD, 1'b0, 64'd5, 64'd7, 64'd0);
    #1 check("add_ctrl", 64'(ALUCtrl), 64'h2);
    check("add_res", ALUResult, 64'd12);
    check("add_zero", 64'(Zero), 64'd0);

    // SUB equal and borrow
    next_cycle();
    set_alu(2'b10, OP_SUB, 1'b0, 64'h1234, 64'h1234, 64'd0);
    #1 check("sub_ctrl", 64'(ALUCtrl), 64'h6);
    check("sub_res", ALUResult, 64'd0);
    check("sub_zero", 64'(Zero), 64'd1);
    next_cycle();
    set_alu(2'b10, OP_SUB, 1'b0, 64'd0, 64'd1, 64'd0);
    #1 check("sub_borrow", ALUResult, 64'hFFFF_FFFF_FFFF_FFFF);

    // AND / ORR / unknown
    next_cycle();
    set_alu(2'b10, OP_AND, 1'b0, 64'hF0F0, 64'h0FF0, 64'd0);
    #1 check("and_res", ALUResult, 64'h00F0);
    check("and_ctrl", 64'(ALUCtrl), 64'h0);
    next_cycle();
    set_alu(2'b10, OP_ORR, 1'b0, 64'hF0F0, 64'h0FF0, 64'd0);
    #1 check("orr_res", ALUResult, 64'hFFF0);
    check("orr_ctrl", 64'(ALUCtrl), 64'h1);
    next_cycle();
    set_alu(2'b10, 11'b11111000010, 1'b0, 64'hF0F0, 64'h0FF0, 64'd0);
    #1 check("unk_ctrl", 64'(ALUCtrl), 64'hF);
    check("unk_res", ALUResult, 64'd0);
    check("unk_zero", 64'(Zero), 64'd1);
    next_cycle();
    set_alu(2'b11, OP_ADD, 1'b0, 64'd5, 64'd7, 64'd0);
    #1 check("op11_ctrl", 64'(ALUCtrl), 64'hF);
    check("op11_res", ALUResult, 64'd0);

    // store 0xDEADBEEF at 16+8
    next_cycle();
    set_alu(2'b00, 11'd0, 1'b1, 64'd16, 64'hDEADBEEF, 64'd8);
    MemoryWrite = 1'b1;
    #1 check("st_addr", ALUResult, 64'd24);
    next_cycle();
    MemoryWrite = 1'b0; MemoryRead = 1'b1;
    #1 check("ld_data", ReadData, 64'hDEADBEEF);
    next_cycle();
    BusA = 64'd16 + 64'd256;
    #1 check("ld_wrap", ReadData, 64'hDEADBEEF);
    next_cycle();
    BusA = 64'd21; Imm = 64'd5;
    #1 check("ld_offset_ignored", ReadData, 64'hDEADBEEF);
    next_cycle();
    MemoryRead = 1'b0;
    #1 check("ld_disabled", ReadData, 64'd0);

    // read during write: old value until the edge
    next_cycle();
    BusA = 64'd16; Imm = 64'd8; BusB = 64'h0123_4567_89AB_CDEF;
    MemoryRead = 1'b1; MemoryWrite = 1'b1;
    #1 check("rdw_old", ReadData, 64'hDEADBEEF);
    next_cycle();
    MemoryWrite = 1'b0;
    #1 check("rdw_new", ReadData, 64'h0123_4567_89AB_CDEF);

    // pass-B / CBZ
    next_cycle();
    MemoryRead = 1'b0;
    set_alu(2'b01, 11'd0, 1'b0, 64'hFFFF, 64'd0, 64'd0);
    #1 check("cbz_res", ALUResult, 64'd0);
    check("cbz_zero", 64'(Zero), 64'd1);
    check("cbz_ctrl", 64'(ALUCtrl), 64'h7);
    next_cycle();
    BusB = 64'd3;
    #1 check("cbnz_zero", 64'(Zero), 64'd0);
    check("cbnz_res", ALUResult, 64'd3);

    // write word 0, then reset pulse mid-cycle
    next_cycle();
    set_alu(2'b00, 11'd0, 1'b1, 64'd0, 64'h55AA, 64'd0);
    MemoryWrite = 1'b1;
    next_cycle();
    MemoryWrite = 1'b0; MemoryRead = 1'b1;
    #1 check("w0_data", ReadData, 64'h55AA);
    #1 Reset = 1'b0;
    #1 check("rst_clear", ReadData, 64'd0);
    check("rst_res_indep", ALUResult, 64'd0);
    BusA = 64'd40;
    #1 check("rst_alu_indep", ALUResult, 64'd40);
    MemoryWrite = 1'b1; BusB = 64'h77;
    next_cycle();
    MemoryWrite = 1'b0;
    Reset = 1'b1;
    #1 check("rst_blocks_wr", ReadData, 64'd0);
    next_cycle();
    BusA = 64'd0;
    #1 check("rst_word0", ReadData, 64'd0);

    next_cycle();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
